// File: rtl/matmul_pkg.sv
// Shared constants and helpers for the matrix multiplier: state codes, index widths, output narrowing.
// Build option MATMUL_SAT_EN: narrow() saturates instead of wrapping.
package matmul_pkg;

  localparam int WIDE_W = 128;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_MAC     = 2'd1;
  localparam state_t S_PRESENT = 2'd2;
  localparam state_t S_DONE    = 2'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic out_of_range(input logic signed [WIDE_W-1:0] v, input int w);
    logic signed [WIDE_W-1:0] one, hi, lo;
    one = WIDE_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // Result carries the narrowed value sign-extended back to WIDE_W; callers keep the low w bits.
  function automatic logic signed [WIDE_W-1:0] narrow(input logic signed [WIDE_W-1:0] v, input int w);
`ifdef MATMUL_SAT_EN
    logic signed [WIDE_W-1:0] one, hi, lo;
    one = WIDE_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
`endif
  endfunction

endpackage

// File: rtl/matmul_mac_engine_mac_unit.sv
// Signed multiply-accumulate slice: acc_next is the accumulator plus the current full-width product.
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;

  assign prod     = $signed(a) * $signed(b);
  assign acc_next = acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_mac_engine.sv
// Fixed-point matrix multiplier Z = A x B (+ C), streaming results row-major over a stb/ack handshake.
// Build option MATMUL_SAT_EN selects saturating rather than wrapping output narrowing.
module matmul_mac_engine
  import matmul_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int INNER  = 8,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  localparam int RI_W  = idx_w(ROWS),
  localparam int KI_W  = idx_w(INNER),
  localparam int CI_W  = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              accumulate,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [OUT_W-1:0]  current_element,
  output logic [RI_W-1:0]   a_i,
  output logic [KI_W-1:0]   a_j,
  output logic [KI_W-1:0]   b_i,
  output logic [CI_W-1:0]   b_j,
  output logic [RI_W-1:0]   z_i,
  output logic [CI_W-1:0]   z_j,
  output logic [OUT_W-1:0]  z_out,
  output logic              z_stb,
  input  logic              z_ack,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int SUM_W = ACC_W + 1;

  state_t                  state;
  logic [RI_W-1:0]         row;
  logic [CI_W-1:0]         col;
  logic [KI_W-1:0]         k;
  logic                    acc_mode;
  logic signed [ACC_W-1:0] acc_fin;
  logic signed [SUM_W-1:0] c_term;
  logic signed [SUM_W-1:0] sum;
  logic                    start_ok, ack_ok, last_k, last_row, last_col;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign ack_ok   = z_ack && (state == S_PRESENT);
  assign last_k   = (k == KI_W'(INNER - 1));
  assign last_row = (row == RI_W'(ROWS - 1));
  assign last_col = (col == CI_W'(COLS - 1));

  assign a_i   = row;
  assign a_j   = k;
  assign b_i   = k;
  assign b_j   = col;
  assign z_i   = row;
  assign z_j   = col;
  assign z_stb = (state == S_PRESENT);

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok || ack_ok),
    .en       (state == S_MAC),
    .a        (a_in),
    .b        (b_in),
    .acc_next (acc_fin)
  );

  // Scale back to the Q format with a flooring shift, then optionally add C in one extra bit of headroom.
  assign c_term = acc_mode ? SUM_W'($signed(current_element)) : SUM_W'(0);
  assign sum    = SUM_W'(acc_fin >>> FRAC_W) + c_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      k        <= '0;
      acc_mode <= 1'b0;
      z_out    <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_MAC;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            acc_mode <= accumulate;
            ovf      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_MAC: begin
          if (last_k) begin
            z_out <= OUT_W'(narrow(WIDE_W'(sum), OUT_W));
            ovf   <= ovf | out_of_range(WIDE_W'(sum), OUT_W);
            state <= S_PRESENT;
          end else begin
            k <= k + KI_W'(1);
          end
        end
        S_PRESENT: begin
          if (z_ack) begin
            k <= '0;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                row   <= row + RI_W'(1);
                state <= S_MAC;
              end
            end else begin
              col   <= col + CI_W'(1);
              state <= S_MAC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_mac_engine.sv
// Self-checking bench for matmul_mac_engine: randomized matrices against an arithmetic reference model.
module tb_matmul_mac_engine;

  localparam int ROWS = 4, INNER = 8, COLS = 4, FRAC = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] A [ROWS][INNER];
  logic signed [15:0] B [INNER][COLS];
  logic signed [31:0] C [ROWS][COLS];

  int errors = 0;
  int checks = 0;

  // Default-width instance
  logic        start = 1'b0, accumulate = 1'b0, z_ack = 1'b0;
  logic [15:0] a_in, b_in;
  logic [31:0] c_in;
  logic [1:0]  a_i, b_j, z_i, z_j;
  logic [2:0]  a_j, b_i;
  logic [31:0] z_out;
  logic        z_stb, busy, done, ovf;

  assign a_in = A[a_i][a_j];
  assign b_in = B[b_i][b_j];
  assign c_in = C[z_i][z_j];

  matmul_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .a_in(a_in), .b_in(b_in), .current_element(c_in),
    .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .z_i(z_i), .z_j(z_j),
    .z_out(z_out), .z_stb(z_stb), .z_ack(z_ack), .busy(busy), .done(done), .ovf(ovf)
  );

  // Narrow-output instance (OUT_W = 16)
  logic        start16 = 1'b0, accumulate16 = 1'b0, ack16 = 1'b0;
  logic [15:0] a16_in, b16_in, c16_in;
  logic [1:0]  a16_i, b16_j, z16_i, z16_j;
  logic [2:0]  a16_j, b16_i;
  logic [15:0] z16_out;
  logic        stb16, busy16, done16, ovf16;

  assign a16_in = A[a16_i][a16_j];
  assign b16_in = B[b16_i][b16_j];
  assign c16_in = 16'(C[z16_i][z16_j]);

  matmul_mac_engine #(.OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .accumulate(accumulate16),
    .a_in(a16_in), .b_in(b16_in), .current_element(c16_in),
    .a_i(a16_i), .a_j(a16_j), .b_i(b16_i), .b_j(b16_j), .z_i(z16_i), .z_j(z16_j),
    .z_out(z16_out), .z_stb(stb16), .z_ack(ack16), .busy(busy16), .done(done16), .ovf(ovf16)
  );

  logic [31:0] got_z [16];
  logic [1:0]  got_i [16];
  logic [1:0]  got_j [16];
  int          n_got;
  bit          timed_out;

  // Reference model: exact integer matrix product, floor-scaled, plus optional C.
  function automatic longint model_sum(int r, int c, bit acc_m);
    longint s = 0;
    for (int kk = 0; kk < INNER; kk++) s += longint'(A[r][kk]) * longint'(B[kk][c]);
    s = s >>> FRAC;
    if (acc_m) s += longint'(C[r][c]);
    return s;
  endfunction

  function automatic longint model_fit(longint s, int w);
    longint lim = longint'(1) <<< (w - 1);
`ifdef MATMUL_SAT_EN
    if (s >= lim) return lim - 1;
    if (s < -lim) return -lim;
    return s;
`else
    longint m;
    m = s & (2 * lim - 1);
    if (m >= lim) m -= 2 * lim;
    return m;
`endif
  endfunction

  function automatic bit model_ovf(longint s, int w);
    longint lim = longint'(1) <<< (w - 1);
    return (s >= lim) || (s < -lim);
  endfunction

  task automatic fill_const(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] cv);
    for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < INNER; kk++) A[r][kk] = av;
    for (int kk = 0; kk < INNER; kk++) for (int c = 0; c < COLS; c++) B[kk][c] = bv;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) C[r][c] = cv;
  endtask

  task automatic fill_rand(input bit wide_c);
    for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < INNER; kk++) A[r][kk] = 16'($urandom);
    for (int kk = 0; kk < INNER; kk++) for (int c = 0; c < COLS; c++) B[kk][c] = 16'($urandom);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        C[r][c] = wide_c ? 32'($urandom) : 32'($signed(25'($urandom)));
  endtask

  // Starts a run on the default instance and records every accepted element.
  task automatic run_collect(input bit acc_m, input bit rand_ack, input bit poke_start);
    int cyc = 0;
    n_got = 0;
    timed_out = 1'b0;
    @(negedge clk);
    start = 1'b1; accumulate = acc_m; z_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done) begin
      if (cyc > 3000) begin timed_out = 1'b1; break; end
      cyc++;
      z_ack = rand_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (z_stb && z_ack) begin
        if (n_got < 16) begin
          got_z[n_got] = z_out; got_i[n_got] = z_i; got_j[n_got] = z_j;
        end
        n_got++;
      end
      @(negedge clk);
    end
    start = 1'b0; z_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; z_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (z_stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got stb=%b busy=%b done=%b ovf=%b want all 0", z_stb, busy, done, ovf);
    end
    checks++;
    if (z_out !== 32'h0 || a_i !== 2'd0 || a_j !== 3'd0 || b_j !== 2'd0 || z_i !== 2'd0 || z_j !== 2'd0) begin
      errors++; $display("FAIL reset_data: got z_out=%h a=%0d,%0d z=%0d,%0d want 0", z_out, a_i, a_j, z_i, z_j);
    end
    checks++;
    if (stb16 !== 1'b0 || busy16 !== 1'b0 || z16_out !== 16'h0) begin
      errors++; $display("FAIL reset_dut16: got stb=%b busy=%b z=%h want 0", stb16, busy16, z16_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_const(16'h0100, 16'h0200, 32'h0);
    run_collect(1'b0, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_got !== 16) begin
      errors++; $display("FAIL basic_count: got %0d elements timeout=%b want 16", n_got, timed_out);
    end
    for (int n = 0; n < 16 && n < n_got; n++) begin
      checks++;
      if (got_z[n] !== 32'h1000 || got_i[n] !== 2'(n / 4) || got_j[n] !== 2'(n % 4)) begin
        errors++; $display("FAIL basic_elem%0d: got (%0d,%0d)=%h want (%0d,%0d)=00001000", n, got_i[n], got_j[n], got_z[n], n / 4, n % 4);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL basic_flags: got done=%b busy=%b ovf=%b want 1 0 0", done, busy, ovf);
    end
  endtask

  task automatic test_accumulate();
    fill_const(16'h0100, 16'h0200, 32'h0100);
    run_collect(1'b1, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_got !== 16) begin
      errors++; $display("FAIL accum_count: got %0d elements timeout=%b want 16", n_got, timed_out);
    end
    for (int n = 0; n < 16 && n < n_got; n++) begin
      checks++;
      if (got_z[n] !== 32'h1100) begin
        errors++; $display("FAIL accum_elem%0d: got %h want 00001100", n, got_z[n]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit acc_m = (it != 0);
      bit want_ovf = 1'b0;
      fill_rand(it == 3);
      run_collect(acc_m, 1'b1, 1'b0);
      checks++;
      if (timed_out || n_got !== 16) begin
        errors++; $display("FAIL rand%0d_count: got %0d elements timeout=%b want 16", it, n_got, timed_out);
      end
      for (int n = 0; n < 16 && n < n_got; n++) begin
        longint s = model_sum(n / 4, n % 4, acc_m);
        logic [31:0] want = 32'(model_fit(s, 32));
        want_ovf |= model_ovf(s, 32);
        checks++;
        if (got_z[n] !== want || got_i[n] !== 2'(n / 4) || got_j[n] !== 2'(n % 4)) begin
          errors++; $display("FAIL rand%0d_elem%0d: got (%0d,%0d)=%h want (%0d,%0d)=%h", it, n, got_i[n], got_j[n], got_z[n], n / 4, n % 4, want);
        end
      end
      checks++;
      if (ovf !== want_ovf || done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_flags: got ovf=%b done=%b want ovf=%b done=1", it, ovf, done, want_ovf);
      end
    end
  endtask

  task automatic test_stall();
    int cyc = 0;
    bit seen = 1'b0;
    logic [31:0] held;
    fill_const(16'h0100, 16'h0200, 32'h0);
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0; z_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 500) begin
      if (z_stb && z_i == 2'd1 && z_j == 2'd2) begin seen = 1'b1; break; end
      @(negedge clk); cyc++;
    end
    z_ack = 1'b0;
    held = z_out;
    checks++;
    if (!seen || held !== 32'h1000) begin
      errors++; $display("FAIL stall_reach: got seen=%b z_out=%h want 1 00001000", seen, held);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (z_stb !== 1'b1 || z_out !== held || z_i !== 2'd1 || z_j !== 2'd2 || a_i !== 2'd1 || a_j !== 3'd7 || b_j !== 2'd2) begin
        errors++; $display("FAIL stall_hold: got stb=%b z=%h z_ij=%0d,%0d a_ij=%0d,%0d b_j=%0d want 1 %h 1,2 1,7 2", z_stb, z_out, z_i, z_j, a_i, a_j, b_j, held);
      end
    end
    z_ack = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!z_stb && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (z_stb !== 1'b1 || z_i !== 2'd1 || z_j !== 2'd3 || z_out !== 32'h1000) begin
      errors++; $display("FAIL stall_resume: got stb=%b (%0d,%0d)=%h want 1 (1,3)=00001000", z_stb, z_i, z_j, z_out);
    end
    cyc = 0;
    while (!done && cyc < 500) begin @(negedge clk); cyc++; end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stall_done: got done=%b want 1", done);
    end
    z_ack = 1'b0;
  endtask

  task automatic test_overflow();
    int n = 0, cyc = 0;
    logic [15:0] want;
`ifdef MATMUL_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'hF800;
`endif
    fill_const(16'h7FFF, 16'h7FFF, 32'h0);
    @(negedge clk);
    start16 = 1'b1; ack16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    while (!done16 && cyc < 1000) begin
      if (stb16) begin
        checks++;
        if (z16_out !== want) begin
          errors++; $display("FAIL ovf_elem%0d: got %h want %h", n, z16_out, want);
        end
        n++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (n !== 16 || done16 !== 1'b1) begin
      errors++; $display("FAIL ovf_count: got %0d elements done=%b want 16 1", n, done16);
    end
    checks++;
    if (ovf16 !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got %b want 1", ovf16);
    end
    ack16 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    fill_const(16'h0100, 16'h0200, 32'h0);
    @(negedge clk);
    start = 1'b1; accumulate = 1'b0; z_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(z_stb && z_i == 2'd0 && z_j == 2'd0) && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (z_stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || z_out !== 32'h0) begin
      errors++; $display("FAIL midrst_ctrl: got stb=%b busy=%b done=%b z=%h want 0", z_stb, busy, done, z_out);
    end
    checks++;
    if (a_i !== 2'd0 || a_j !== 3'd0 || b_i !== 3'd0 || b_j !== 2'd0 || z_i !== 2'd0 || z_j !== 2'd0) begin
      errors++; $display("FAIL midrst_addr: got a=%0d,%0d b=%0d,%0d z=%0d,%0d want 0", a_i, a_j, b_i, b_j, z_i, z_j);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    repeat (20) begin @(negedge clk); if (z_stb || busy) cyc++; end
    checks++;
    if (cyc !== 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles after reset want 0", cyc);
    end
    z_ack = 1'b0;
    fill_rand(1'b0);
    run_collect(1'b1, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_got !== 16) begin
      errors++; $display("FAIL midrst_count: got %0d elements timeout=%b want 16", n_got, timed_out);
    end
    for (int n = 0; n < 16 && n < n_got; n++) begin
      logic [31:0] want = 32'(model_fit(model_sum(n / 4, n % 4, 1'b1), 32));
      checks++;
      if (got_z[n] !== want) begin
        errors++; $display("FAIL midrst_elem%0d: got %h want %h", n, got_z[n], want);
      end
    end
  endtask

  task automatic test_ignored();
    int cyc = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    z_ack = 1'b1;
    repeat (3) @(negedge clk);
    z_ack = 1'b0;
    checks++;
    if (z_stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_ack: got stb=%b busy=%b done=%b want 0", z_stb, busy, done);
    end
    fill_const(16'h0100, 16'h0200, 32'h0);
    run_collect(1'b0, 1'b0, 1'b1);
    checks++;
    if (timed_out || n_got !== 16) begin
      errors++; $display("FAIL poke_count: got %0d elements timeout=%b want 16", n_got, timed_out);
    end
    for (int n = 0; n < 16 && n < n_got; n++) begin
      checks++;
      if (got_z[n] !== 32'h1000 || got_i[n] !== 2'(n / 4) || got_j[n] !== 2'(n % 4)) begin
        errors++; $display("FAIL poke_elem%0d: got (%0d,%0d)=%h want (%0d,%0d)=00001000", n, got_i[n], got_j[n], got_z[n], n / 4, n % 4);
      end
    end
    repeat (10) begin @(negedge clk); if (done !== 1'b1 || z_stb !== 1'b0) cyc++; end
    checks++;
    if (cyc !== 0) begin
      errors++; $display("FAIL done_hold: got %0d cycles with done low or stb high want 0", cyc);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart: got done=%b busy=%b want 0 1", done, busy);
    end
    z_ack = 1'b1;
    cyc = 0;
    while (!done && cyc < 500) begin @(negedge clk); cyc++; end
    z_ack = 1'b0;
  endtask

  initial begin
    fill_const(16'h0, 16'h0, 32'h0);
    test_reset();
    test_basic();
    test_accumulate();
    test_stall();
    test_random();
    test_overflow();
    test_reset_mid();
    test_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
